// File: rtl/alif_cfg_pkg.sv
// Shared types and constants for the ALIF neuron configuration loader.
// Frame layout: header, four payload bytes, XOR checksum.
package alif_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_COMMIT
  } cfg_state_t;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  localparam int IDX_WEIGHT = 0;
  localparam int IDX_LEAK   = 1;
  localparam int IDX_THRMIN = 2;
  localparam int IDX_CYC    = 3;

  typedef struct packed {
    logic [2:0] weight;
    logic [7:0] leak_rate;
    logic [7:0] threshold_min;
    logic [3:0] leak_cycles;
  } alif_params_t;

  function automatic logic [7:0] frame_ck(input logic [7:0] p0, input logic [7:0] p1,
                                          input logic [7:0] p2, input logic [7:0] p3);
    return p0 ^ p1 ^ p2 ^ p3;
  endfunction

endpackage

// File: rtl/alif_tick_divider.sv
// Input-sampling tick: strobes once every (div+1) enabled cycles, restarting
// from the full period whenever the neuron is not enabled.
module alif_tick_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       strobe_o
);

  logic [3:0] div_q;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (!en_i || cnt_q == 4'd0) begin
      cnt_d = div_q;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (load_i) begin
        div_q <= load_val_i;
      end
    end
  end

  assign strobe_o = en_i && (cnt_q == 4'd0);

endmodule

// File: rtl/alif_param_loader.sv
// Framed, checksummed parameter loader for the ALIF neuron: validates host
// frames, commits them atomically, and sequences reset/enable/input ticks.
module alif_param_loader
  import alif_cfg_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT,
  parameter int         PAYLOAD_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  input  logic       run,
  output logic [2:0] weight_a,
  output logic [7:0] leak_rate,
  output logic [7:0] threshold_min,
  output logic [3:0] leak_cycles,
  output logic       params_ready,
  output logic       neuron_reset,
  output logic       neuron_enable,
  output logic       input_enable,
  output logic       cfg_err
);

  localparam logic [1:0] LAST_IDX = 2'(PAYLOAD_LEN - 1);

  cfg_state_t   state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   shadow_q [PAYLOAD_LEN];
  logic [PAYLOAD_LEN-1:0] shadow_we;
  alif_params_t active_q;
  logic         params_ready_q;
  logic         cfg_err_q;
  logic         accept;
  logic         commit;
  logic         reject;
  logic         frame_ok;

  assign cfg_ready = (state_q != ST_COMMIT);
  assign accept    = cfg_valid && cfg_ready;

  // The checksum is folded from the shadow bytes, so it always reflects
  // exactly the payload that would be committed.
  assign frame_ok = (cfg_data == frame_ck(shadow_q[IDX_WEIGHT], shadow_q[IDX_LEAK],
                                          shadow_q[IDX_THRMIN], shadow_q[IDX_CYC]))
                    && (shadow_q[IDX_THRMIN] != 8'd0);

  for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_shadow_we
    assign shadow_we[gi] = (state_q == ST_LOAD) && accept && (idx_q == 2'(gi));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && cfg_data == HDR_BYTE) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (frame_ok) begin
            commit  = 1'b1;
            state_d = ST_COMMIT;
          end else begin
            reject  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      active_q       <= '0;
      params_ready_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int i = 0; i < PAYLOAD_LEN; i++) begin
        if (shadow_we[i]) begin
          shadow_q[i] <= cfg_data;
        end
      end
      if (commit) begin
        active_q.weight        <= shadow_q[IDX_WEIGHT][2:0];
        active_q.leak_rate     <= shadow_q[IDX_LEAK];
        active_q.threshold_min <= shadow_q[IDX_THRMIN];
        active_q.leak_cycles   <= shadow_q[IDX_CYC][3:0];
        params_ready_q         <= 1'b1;
        cfg_err_q              <= 1'b0;
      end else if (reject) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  assign weight_a      = active_q.weight;
  assign leak_rate     = active_q.leak_rate;
  assign threshold_min = active_q.threshold_min;
  assign leak_cycles   = active_q.leak_cycles;
  assign params_ready  = params_ready_q;
  assign cfg_err       = cfg_err_q;
  // The neuron sees its reset pulse during the single COMMIT cycle.
  assign neuron_reset  = (state_q == ST_COMMIT);
  assign neuron_enable = params_ready_q & run & ~neuron_reset;

  alif_tick_divider u_tick (
    .clk        (clk),
    .reset      (reset),
    .load_i     (commit),
    .load_val_i (shadow_q[IDX_CYC][7:4]),
    .en_i       (neuron_enable),
    .strobe_o   (input_enable)
  );

endmodule

// File: tb/tb_alif_param_loader.sv
// Self-checking bench for alif_param_loader: frame-level reference model
// compared every cycle, plus directed literal checks.
module tb_alif_param_loader;

  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;
  logic       run = 1'b0;
  logic       cfg_ready;
  logic [2:0] weight_a;
  logic [7:0] leak_rate;
  logic [7:0] threshold_min;
  logic [3:0] leak_cycles;
  logic       params_ready;
  logic       neuron_reset;
  logic       neuron_enable;
  logic       input_enable;
  logic       cfg_err;

  always #5 clk = ~clk;

  alif_param_loader dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .run           (run),
    .weight_a      (weight_a),
    .leak_rate     (leak_rate),
    .threshold_min (threshold_min),
    .leak_cycles   (leak_cycles),
    .params_ready  (params_ready),
    .neuron_reset  (neuron_reset),
    .neuron_enable (neuron_enable),
    .input_enable  (input_enable),
    .cfg_err       (cfg_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes since a header are buffered; a full six-byte
  // frame is judged as a whole.
  logic [2:0] m_w;
  logic [7:0] m_leak;
  logic [7:0] m_thr;
  logic [3:0] m_cyc;
  logic [3:0] m_div;
  bit         m_ready;
  bit         m_err;
  bit         m_commit;
  int         m_en_run;
  logic [7:0] mbuf[$];
  bit         chk_on = 1'b0;
  bit         m_en;
  bit         m_commit_now;
  logic [7:0] m_ck;

  always @(posedge clk) begin
    if (reset) begin
      m_w = '0; m_leak = '0; m_thr = '0; m_cyc = '0; m_div = '0;
      m_ready = 0; m_err = 0; m_commit = 0; m_en_run = 0;
      mbuf.delete();
    end else begin
      m_commit_now = 0;
      m_en = m_ready && run && !m_commit;
      m_en_run = m_en ? m_en_run + 1 : 0;
      if (cfg_valid && !m_commit) begin
        if (mbuf.size() == 0) begin
          if (cfg_data == HDR) mbuf.push_back(cfg_data);
        end else begin
          mbuf.push_back(cfg_data);
          if (mbuf.size() == 6) begin
            m_ck = mbuf[1] ^ mbuf[2] ^ mbuf[3] ^ mbuf[4];
            if (m_ck == mbuf[5] && mbuf[3] != 8'd0) begin
              m_w    = mbuf[1][2:0];
              m_leak = mbuf[2];
              m_thr  = mbuf[3];
              m_cyc  = mbuf[4][3:0];
              m_div  = mbuf[4][7:4];
              m_ready = 1;
              m_err   = 0;
              m_commit_now = 1;
            end else begin
              m_err = 1;
            end
            mbuf.delete();
          end
        end
      end
      m_commit = m_commit_now;
    end
  end

  bit e_en;
  bit e_ie;
  always @(negedge clk) begin
    if (chk_on) begin
      e_en = m_ready && run && !m_commit;
      e_ie = e_en && ((m_en_run % (int'(m_div) + 1)) == int'(m_div));
      chk("weight_a", weight_a, m_w);
      chk("leak_rate", leak_rate, m_leak);
      chk("threshold_min", threshold_min, m_thr);
      chk("leak_cycles", leak_cycles, m_cyc);
      chk("params_ready", params_ready, m_ready);
      chk("neuron_reset", neuron_reset, m_commit);
      chk("cfg_ready", cfg_ready, !m_commit);
      chk("cfg_err", cfg_err, m_err);
      chk("neuron_enable", neuron_enable, e_en);
      chk("input_enable", input_enable, e_ie);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (!cfg_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (!cfg_ready) chk("cfg_ready_wait", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_data  = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3, input bit bad_ck);
    logic [7:0] ck;
    ck = p0 ^ p1 ^ p2 ^ p3;
    if (bad_ck) ck = ~ck;
    send_byte(HDR);
    send_byte(p0);
    send_byte(p1);
    send_byte(p2);
    send_byte(p3);
    send_byte(ck);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_params_ready", params_ready, 0);
    chk("rst_weight", weight_a, 0);
    chk("rst_input_enable", input_enable, 0);

    // Garbage in IDLE, then the reference good frame (checksum 0x0A).
    send_byte(8'h00);
    send_byte(8'hFF);
    run = 1'b1;
    send_frame(8'h05, 8'h10, 8'h20, 8'h3F, 0);
    chk("c1_params_ready", params_ready, 1);
    chk("c1_neuron_reset", neuron_reset, 1);
    chk("c1_cfg_ready", cfg_ready, 0);
    chk("c1_weight", weight_a, 5);
    chk("c1_leak", leak_rate, 16);
    chk("c1_thr", threshold_min, 32);
    chk("c1_cyc", leak_cycles, 15);
    chk("c1_enable_t1", neuron_enable, 0);
    tick();
    chk("c1_neuron_reset_t2", neuron_reset, 0);
    chk("c1_cfg_ready_t2", cfg_ready, 1);
    chk("c1_enable_t2", neuron_enable, 1);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cnt += int'(input_enable);
      tick();
    end
    chk("strobes_div3", cnt, 4);

    // Bad checksum leaves the active set alone.
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 1);
    chk("bad_ck_err", cfg_err, 1);
    chk("bad_ck_weight", weight_a, 5);
    chk("bad_ck_ready", params_ready, 1);

    // threshold_min = 0 is rejected even with a correct checksum.
    send_frame(8'h07, 8'h11, 8'h00, 8'h20, 0);
    chk("thr0_err", cfg_err, 1);
    chk("thr0_thr", threshold_min, 32);

    // Good frame with tick_div = 0 clears the error.
    send_frame(8'h03, 8'h22, 8'h40, 8'h05, 0);
    chk("c2_err", cfg_err, 0);
    chk("c2_weight", weight_a, 3);
    chk("c2_leak", leak_rate, 8'h22);
    chk("c2_thr", threshold_min, 8'h40);
    chk("c2_cyc", leak_cycles, 5);
    tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cnt += int'(input_enable);
      tick();
    end
    chk("strobes_div0", cnt, 8);
    run = 1'b0;
    #1;
    chk("run_drop_ie", input_enable, 0);
    chk("run_drop_en", neuron_enable, 0);
    @(posedge clk);
    #1;
    run = 1'b1;
    repeat (3) tick();

    // Header value inside the payload is data.
    send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 0);
    chk("c3_weight", weight_a, 5);
    chk("c3_leak", leak_rate, 8'h12);
    chk("c3_thr", threshold_min, 8'h34);
    chk("c3_cyc", leak_cycles, 6);
    repeat (14) tick();

    // Stalled frame: five idle cycles mid-payload.
    send_byte(HDR);
    send_byte(8'h01);
    send_byte(8'h09);
    repeat (5) tick();
    send_byte(8'h08);
    send_byte(8'h72);
    send_byte(8'h72);
    chk("stall_weight", weight_a, 1);
    chk("stall_leak", leak_rate, 9);
    chk("stall_thr", threshold_min, 8);
    chk("stall_cyc", leak_cycles, 2);
    repeat (20) tick();

    // Reset after P1 drops both the partial frame and the active set.
    send_byte(HDR);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", params_ready, 0);
    chk("mid_rst_weight", weight_a, 0);
    chk("mid_rst_thr", threshold_min, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    tick();
    send_frame(8'h05, 8'h10, 8'h20, 8'h3F, 0);
    chk("c4_ready", params_ready, 1);
    chk("c4_weight", weight_a, 5);
    chk("c4_thr", threshold_min, 32);
    repeat (12) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
